// File: rtl/dvi_palette_ctrl.sv
// Palette RAM write sequencer: queued host updates and hardware range fills,
// both committed only while the commit window (vblank or immediate) is open.
module dvi_palette_ctrl #(
  parameter int W_ADDR     = 8,
  parameter int W_DATA     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vblank,
  input  logic                          immediate,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [W_ADDR-1:0]             upd_addr,
  input  logic [W_DATA-1:0]             upd_data,
  input  logic                          fill_start,
  input  logic [W_ADDR-1:0]             fill_first,
  input  logic [W_ADDR-1:0]             fill_last,
  input  logic [W_DATA-1:0]             fill_data,
  output logic                          fill_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pal_wen,
  output logic [W_ADDR-1:0]             pal_waddr,
  output logic [W_DATA-1:0]             pal_wdata
);

  localparam int W_PTR = $clog2(FIFO_DEPTH);
  localparam int W_LVL = W_PTR + 1;
  localparam int W_ENT = W_ADDR + W_DATA;

  typedef enum logic [1:0] {IDLE, FILL_WAIT, FILL} state_t;

  state_t                state_reg, state_next;
  logic [W_ENT-1:0]      fifo_mem [FIFO_DEPTH];
  logic [W_PTR-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [W_LVL-1:0]      level_reg;
  logic [W_ADDR-1:0]     fill_cur_reg, fill_last_reg;
  logic [W_DATA-1:0]     fill_data_reg;
  logic                  pal_wen_reg;
  logic [W_ADDR-1:0]     pal_waddr_reg;
  logic [W_DATA-1:0]     pal_wdata_reg;

  logic win, fifo_empty, push, pop, fill_issue, fill_accept;

  always_comb begin
    win         = vblank | immediate;
    fifo_empty  = (level_reg == '0);
    fill_busy   = (state_reg != IDLE);
    upd_ready   = (level_reg != W_LVL'(FIFO_DEPTH)) && !fill_busy;
    push        = upd_valid && upd_ready;
    // The FIFO may drain in IDLE and FILL_WAIT; during FILL it is empty by construction.
    pop         = win && !fifo_empty && (state_reg != FILL);
    fill_issue  = win && (state_reg == FILL);
    fill_accept = fill_start && (state_reg == IDLE);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (fill_accept) state_next = FILL_WAIT;
      FILL_WAIT: if (fifo_empty && win) state_next = FILL;
      FILL:      if (fill_issue && (fill_cur_reg == fill_last_reg)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + W_PTR'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + W_PTR'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + W_LVL'(1);
        2'b01:   level_reg <= level_reg - W_LVL'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Queue storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {upd_addr, upd_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cur_reg  <= '0;
      fill_last_reg <= '0;
      fill_data_reg <= '0;
    end else if (fill_accept) begin
      fill_cur_reg  <= fill_first;
      fill_last_reg <= fill_last;
      fill_data_reg <= fill_data;
    end else if (fill_issue) begin
      fill_cur_reg  <= fill_cur_reg + W_ADDR'(1);
    end
  end

  // Registered write port; address/data hold when nothing is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pal_wen_reg   <= 1'b0;
      pal_waddr_reg <= '0;
      pal_wdata_reg <= '0;
    end else begin
      pal_wen_reg <= pop | fill_issue;
      if (pop) begin
        {pal_waddr_reg, pal_wdata_reg} <= fifo_mem[rd_ptr_reg];
      end else if (fill_issue) begin
        pal_waddr_reg <= fill_cur_reg;
        pal_wdata_reg <= fill_data_reg;
      end
    end
  end

  assign fifo_level = level_reg;
  assign pal_wen    = pal_wen_reg;
  assign pal_waddr  = pal_waddr_reg;
  assign pal_wdata  = pal_wdata_reg;

endmodule

// File: doc/dvi_palette_ctrl.md
Name: dvi_palette_ctrl

Overview:
- Sequences all writes into the DVI palette RAM's write port (enable/address/data, one entry per cycle).
- Host updates are queued in a small FIFO. They are committed only inside a commit window: vblank high, or the immediate override set.
- Also runs a hardware range fill (one colour to a contiguous, possibly wrapping, index range), ordered after any queued updates.
- Sits between the framebuffer's AHB-Lite register block and the palette memory. The scanout read port is untouched.

Parameters:
- W_ADDR, 8, palette index width.
- W_DATA, 24, palette colour width (RGB888).
- FIFO_DEPTH, 4, update queue depth; power of two, ≥2.

Ports:
- clk  in  1  system clock; same clock as the palette write port.
- rst_n  in  1  reset; synchronous, active-low.
- vblank  in  1  commit window open (synchronous to clk).
- immediate  in  1  config: 1 = ignore vblank, window always open.
- upd_valid  in  1  host update request.
- upd_ready  out  1  update accepted when upd_valid && upd_ready.
- upd_addr  in  W_ADDR  update index.
- upd_data  in  W_DATA  update colour.
- fill_start  in  1  single-cycle fill request.
- fill_first  in  W_ADDR  first fill index.
- fill_last  in  W_ADDR  last fill index (inclusive).
- fill_data  in  W_DATA  fill colour.
- fill_busy  out  1  fill accepted and not yet fully issued.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entry count.
- pal_wen  out  1  palette write enable (registered).
- pal_waddr  out  W_ADDR  palette write address (registered).
- pal_wdata  out  W_DATA  palette write data (registered).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE; FIFO empty; fifo_level=0; fill_busy=0.
  - pal_wen=0, pal_waddr=0, pal_wdata=0.
  - upd_ready reads 1 from the first cycle after reset.
  - Reset mid-fill or mid-drain abandons all pending work; no further pal_wen.
- Window: win = vblank | immediate, sampled each cycle.
- upd_ready = (fifo_level != FIFO_DEPTH) && !fill_busy, combinational from registered state.
  - No bypass: a push into a full FIFO is impossible.
  - An update offered while fill_busy stalls until the fill completes.
- Queue rules:
  - A pushed entry is visible at the FIFO head the next cycle.
  - Push and pop in the same cycle: level unchanged.
- Pop and issue:
  - Pop at cycle N when win && FIFO non-empty && state is not FILL.
  - At N+1: pal_wen=1, with pal_waddr/pal_wdata equal to the popped entry.
  - Minimum push-to-write latency is 2 cycles. Entries commit in push order, one per cycle while win holds.
- States:
  - IDLE → FILL_WAIT on fill_start when fill_busy=0. Latch first/last/data; cur=fill_first; fill_busy=1 from the next cycle.
  - fill_start while fill_busy=1 is ignored.
  - FILL_WAIT: the FIFO keeps draining. Go to FILL when the FIFO is empty (fifo_level==0) and win.
  - FILL: each cycle with win, issue pal_wen=1, pal_waddr=cur, pal_wdata=latched colour.
    - If cur==last, go to IDLE (fill_busy=0 next cycle). Otherwise cur=cur+1 mod 2^W_ADDR.
- Fill range arithmetic:
  - Write count = ((last − first) mod 2^W_ADDR) + 1.
  - first==last gives 1 write.
  - last<first wraps through 2^W_ADDR−1 to 0.
  - first=0, last=all-ones gives 2^W_ADDR writes.
- Window closing mid-drain or mid-fill:
  - No new pop or issue in any cycle with win=0.
  - A write already registered still appears (pal_wen asserted one cycle).
  - Work resumes from the exact next entry/index when win reopens.
- pal_wen is low in every cycle with nothing issued. pal_waddr/pal_wdata hold their last values.
- There is never more than one palette write per cycle, and FIFO and fill writes never interleave.

Test Plan:
- Reset, immediate=1: push (0x05,0x112233) → pal_wen high exactly 2 cycles after the push with addr 0x05, data 0x112233; fifo_level 1 then 0.
- immediate=0, vblank=0: push 4 entries → upd_ready=0, fifo_level=4, no pal_wen. Raise vblank → 4 consecutive writes in push order, then upd_ready=1.
- Fill first=0xFE, last=0x01, data 0xABCDEF, win=1 → exactly 4 writes to 0xFE,0xFF,0x00,0x01. fill_busy drops the cycle after the last write.
- 2 entries queued with vblank=0, then fill_start(first=0x10,last=0x12) and a new upd_valid offered → upd_ready=0. On vblank: 2 FIFO writes, then 3 fill writes. The new update is accepted only after fill_busy=0.
- Drop vblank after 2 of 5 fill writes → pal_wen stops after at most one further write. On reopen, resumes at the next index; 5 total distinct writes.
- Assert rst_n=0 mid-fill → next cycle pal_wen=0, fill_busy=0, fifo_level=0. No writes occur after reset releases.
